// File: rtl/draw_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : draw_scheduler                                               |
// | Description : Shares the single-pixel framebuffer write port between a     |
// |               full-screen clear sweep and a queued line_drawer stream.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module draw_scheduler #(
  parameter int X_W      = 11,
  parameter int Y_W      = 11,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int QDEPTH   = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear_req,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [X_W-1:0] cmd_x0,
  input  logic [X_W-1:0] cmd_x1,
  input  logic [Y_W-1:0] cmd_y0,
  input  logic [Y_W-1:0] cmd_y1,
  input  logic           cmd_color,
  output logic           ld_start,
  output logic [X_W-1:0] ld_x0,
  output logic [X_W-1:0] ld_x1,
  output logic [Y_W-1:0] ld_y0,
  output logic [Y_W-1:0] ld_y1,
  input  logic [X_W-1:0] ld_x,
  input  logic [Y_W-1:0] ld_y,
  input  logic           ld_valid,
  input  logic           ld_done,
  output logic [X_W-1:0] fb_x,
  output logic [Y_W-1:0] fb_y,
  output logic           fb_color,
  output logic           fb_write,
  output logic           busy
);

  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(QDEPTH);
  localparam logic [X_W-1:0] X_LAST  = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(SCREEN_H - 1);
  localparam logic [X_W-1:0] X_LIM   = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0] Y_LIM   = Y_W'(SCREEN_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    LOAD  = 2'd2,
    DRAW  = 2'd3
  } state_t;

  state_t state;
  state_t state_nx;

  // Line-command FIFO storage and bookkeeping
  logic [X_W-1:0] q_x0 [QDEPTH];
  logic [X_W-1:0] q_x1 [QDEPTH];
  logic [Y_W-1:0] q_y0 [QDEPTH];
  logic [Y_W-1:0] q_y1 [QDEPTH];
  logic           q_c  [QDEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  logic           full;
  logic           empty;

  // Clear sweep and dispatch control
  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           cx_last;
  logic           cy_last;
  logic           clear_pend;
  logic           enter_clear;
  logic           load_head;
  logic           line_color;
  logic           pix_in_range;

  assign full      = (count == DEPTH_C);
  assign empty     = (count == '0);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  // The pop happens in LOAD; the head was already copied out on the way in.
  assign pop       = (state == LOAD);

  assign cx_last      = (cx == X_LAST);
  assign cy_last      = (cy == Y_LAST);
  assign pix_in_range = (ld_x < X_LIM) && (ld_y < Y_LIM);

  assign ld_start = (state == LOAD);
  assign busy     = (state != IDLE);

  // FIFO payload write; contents need no reset because occupancy gates reads
  always_ff @(posedge clk) begin
    if (push) begin
      q_x0[wr_ptr] <= cmd_x0;
      q_x1[wr_ptr] <= cmd_x1;
      q_y0[wr_ptr] <= cmd_y0;
      q_y1[wr_ptr] <= cmd_y1;
      q_c[wr_ptr]  <= cmd_color;
    end
  end

  // FIFO pointers wrap naturally since QDEPTH is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next-state selection; a pending clear always beats a queued line
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (clear_pend || clear_req) state_nx = CLEAR;
        else if (!empty)             state_nx = LOAD;
      end
      CLEAR: begin
        if (cx_last && cy_last) state_nx = IDLE;
      end
      LOAD: state_nx = DRAW;
      DRAW: begin
        if (ld_done) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign enter_clear = (state == IDLE) && (state_nx == CLEAR);
  assign load_head   = (state == IDLE) && (state_nx == LOAD);

  // State register, clear-request memory and raster counter for the sweep
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      clear_pend <= 1'b0;
      cx         <= '0;
      cy         <= '0;
    end else begin
      state <= state_nx;
      if (enter_clear)    clear_pend <= 1'b0;
      else if (clear_req) clear_pend <= 1'b1;
      if (enter_clear) begin
        cx <= '0;
        cy <= '0;
      end else if (state == CLEAR) begin
        if (cx_last) begin
          cx <= '0;
          cy <= cy + 1'b1;
        end else begin
          cx <= cx + 1'b1;
        end
      end
    end
  end

  // Copy the FIFO head when heading into LOAD so endpoints are valid with ld_start
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ld_x0      <= '0;
      ld_x1      <= '0;
      ld_y0      <= '0;
      ld_y1      <= '0;
      line_color <= 1'b0;
    end else if (load_head) begin
      ld_x0      <= q_x0[rd_ptr];
      ld_x1      <= q_x1[rd_ptr];
      ld_y0      <= q_y0[rd_ptr];
      ld_y1      <= q_y1[rd_ptr];
      line_color <= q_c[rd_ptr];
    end
  end

  // Registered framebuffer port: sweep pixels in CLEAR, clipped line pixels in DRAW
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fb_x     <= '0;
      fb_y     <= '0;
      fb_color <= 1'b0;
      fb_write <= 1'b0;
    end else begin
      fb_write <= 1'b0;
      if (state == CLEAR) begin
        fb_x     <= cx;
        fb_y     <= cy;
        fb_color <= 1'b0;
        fb_write <= 1'b1;
      end else if ((state == DRAW) && ld_valid && pix_in_range) begin
        fb_x     <= ld_x;
        fb_y     <= ld_y;
        fb_color <= line_color;
        fb_write <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_draw_scheduler                                            |
// | Description : Scoreboard bench for draw_scheduler with a line_drawer model |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_draw_scheduler;

  localparam int SW = 8;
  localparam int SH = 4;
  localparam int QD = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        clear_req;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] cmd_x0, cmd_x1, cmd_y0, cmd_y1;
  logic        cmd_color;
  logic        ld_start;
  logic [10:0] ld_x0, ld_x1, ld_y0, ld_y1;
  logic [10:0] ld_x, ld_y;
  logic        ld_valid, ld_done;
  logic [10:0] fb_x, fb_y;
  logic        fb_color, fb_write, busy;

  draw_scheduler #(
    .X_W(11), .Y_W(11), .SCREEN_W(SW), .SCREEN_H(SH), .QDEPTH(QD)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_x1(cmd_x1), .cmd_y0(cmd_y0), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color),
    .ld_start(ld_start), .ld_x0(ld_x0), .ld_x1(ld_x1), .ld_y0(ld_y0), .ld_y1(ld_y1),
    .ld_x(ld_x), .ld_y(ld_y), .ld_valid(ld_valid), .ld_done(ld_done),
    .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color), .fb_write(fb_write),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] x;
    logic [10:0] y;
    logic        c;
    int          cyc;   // >=0 exact cycle, -2 consecutive with previous, -1 any
  } pix_t;

  typedef struct {
    logic [10:0] x0, y0, x1, y1;
    logic        c;
  } cmd_t;

  pix_t exp_q[$];
  cmd_t cmd_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_fb_cyc = 0;
  int mcount = 0;
  int starts = 0;
  int fb_cnt = 0;
  int stall = 0;
  bit saw_full = 0;
  bit drawing = 0;
  bit clr_pending = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_clear(input int first_cyc);
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++)
        exp_q.push_back('{x: 11'(x), y: 11'(y), c: 1'b0,
                          cyc: (x == 0 && y == 0) ? first_cyc : -2});
  endtask

  // Called at posedge+1 while the DUT is idle
  task automatic clear_from_idle();
    clear_req = 1'b1;
    push_clear(cyc + 2);
    step();
    clear_req = 1'b0;
  endtask

  task automatic push_cmd(input logic [10:0] x0, input logic [10:0] y0,
                          input logic [10:0] x1, input logic [10:0] y1, input logic c);
    int n;
    cmd_valid = 1'b1;
    cmd_x0 = x0; cmd_y0 = y0; cmd_x1 = x1; cmd_y1 = y1; cmd_color = c;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cmd_ready && n < 200);
    if (!cmd_ready) check("push_timeout", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || cmd_q.size() != 0 || drawing || busy) && n < 3000);
    check("idle_pending_pixels", exp_q.size(), 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic drive_pix(input logic [10:0] x, input logic [10:0] y, input logic c,
                           input logic done);
    ld_valid = 1'b1;
    ld_x = x;
    ld_y = y;
    ld_done = done;
    if (x < SW && y < SH) exp_q.push_back('{x: x, y: y, c: c, cyc: cyc + 1});
    step();
    ld_valid = 1'b0;
    ld_done = 1'b0;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: FIFO occupancy model, command capture and fb scoreboard
  always @(negedge clk) begin
    pix_t p;
    if (!reset_n) begin
      exp_q.delete();
      cmd_q.delete();
      mcount = 0;
    end else begin
      check("cmd_ready", cmd_ready, (mcount != QD));
      if (!cmd_ready) saw_full = 1'b1;
      if (fb_write) begin
        fb_cnt++;
        if (exp_q.size() == 0) begin
          check("fb_unexpected", fb_write, 0);
        end else begin
          p = exp_q.pop_front();
          check("fb_x", fb_x, p.x);
          check("fb_y", fb_y, p.y);
          check("fb_color", fb_color, p.c);
          if (p.cyc >= 0)       check("fb_latency", cyc, p.cyc);
          else if (p.cyc == -2) check("fb_consecutive", cyc, last_fb_cyc + 1);
        end
        last_fb_cyc = cyc;
      end
      if (ld_start) begin
        starts++;
        mcount--;
      end
      if (cmd_valid && cmd_ready) begin
        cmd_q.push_back('{x0: cmd_x0, y0: cmd_y0, x1: cmd_x1, y1: cmd_y1, c: cmd_color});
        mcount++;
      end
    end
  end

  // line_drawer model: three pixels per line (with a gap), done on the last
  initial begin
    cmd_t c;
    int st;
    ld_valid = 1'b0; ld_done = 1'b0; ld_x = '0; ld_y = '0;
    forever begin
      @(negedge clk);
      if (reset_n && ld_start) begin
        drawing = 1'b1;
        if (cmd_q.size() == 0) begin
          check("ld_start_unexpected", ld_start, 0);
        end else begin
          c = cmd_q.pop_front();
          check("ld_x0", ld_x0, c.x0);
          check("ld_y0", ld_y0, c.y0);
          check("ld_x1", ld_x1, c.x1);
          check("ld_y1", ld_y1, c.y1);
          st = stall;
          stall = 0;
          step();
          repeat (st) step();
          drive_pix(c.x0, c.y0, c.c, 1'b0);
          step();
          drive_pix(c.x0 + 11'd1, c.y0, c.c, 1'b0);
          drive_pix(c.x1, c.y1, c.c, 1'b1);
          check("ld_hold_x1", ld_x1, c.x1);
          check("ld_hold_y0", ld_y0, c.y0);
          if (clr_pending) begin
            push_clear(-1);
            clr_pending = 1'b0;
          end
        end
        drawing = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, f0, n;
    reset_n = 1'b0; clear_req = 1'b0; cmd_valid = 1'b0;
    cmd_x0 = '0; cmd_x1 = '0; cmd_y0 = '0; cmd_y1 = '0; cmd_color = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_fb_write", fb_write, 0);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_ld_start", ld_start, 0);
    check("rst_fb_xy", {fb_x, fb_y}, 0);
    check("rst_ld_x1", ld_x1, 0);
    step();
    reset_n = 1'b1;
    step();

    // 1: full clear from idle
    f0 = fb_cnt;
    clear_from_idle();
    wait_idle();
    check("clear_writes", fb_cnt - f0, SW * SH);
    @(negedge clk);
    check("clear_busy_after", busy, 0);
    step();

    // 2: single line dispatch
    s0 = starts;
    push_cmd(11'd0, 11'd0, 11'd120, 11'd45, 1'b1);
    wait_idle();
    check("single_starts", starts - s0, 1);
    step();

    // 3: fill the FIFO while the first line is stalled
    s0 = starts;
    saw_full = 1'b0;
    stall = 15;
    push_cmd(11'd0, 11'd0, 11'd3, 11'd1, 1'b1);
    push_cmd(11'd1, 11'd1, 11'd5, 11'd2, 1'b0);
    push_cmd(11'd2, 11'd2, 11'd6, 11'd3, 1'b1);
    push_cmd(11'd3, 11'd3, 11'd7, 11'd0, 1'b0);
    push_cmd(11'd4, 11'd0, 11'd2, 11'd2, 1'b1);
    push_cmd(11'd5, 11'd1, 11'd0, 11'd3, 1'b1);
    push_cmd(11'd6, 11'd2, 11'd1, 11'd1, 1'b0);
    wait_idle();
    check("fifo_saw_full", saw_full, 1);
    check("fifo_starts", starts - s0, 7);
    step();

    // 4: clear requested mid-line with one command queued
    s0 = starts;
    stall = 10;
    push_cmd(11'd1, 11'd0, 11'd4, 11'd2, 1'b1);
    n = 0;
    while (!drawing && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("mid_draw_started", drawing, 1);
    step();
    push_cmd(11'd2, 11'd1, 11'd6, 11'd3, 1'b1);
    clr_pending = 1'b1;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    wait_idle();
    check("mid_clear_starts", starts - s0, 2);
    step();

    // 5: off-screen pixels are dropped, boundary pixels kept
    push_cmd(11'd7, 11'd1, 11'd10, 11'd4, 1'b1);
    push_cmd(11'd0, 11'd3, 11'd1, 11'd4, 1'b1);
    wait_idle();
    step();

    // 6: reset mid-clear with two commands queued
    clear_from_idle();
    push_cmd(11'd1, 11'd1, 11'd2, 11'd2, 1'b1);
    push_cmd(11'd3, 11'd3, 11'd4, 11'd0, 1'b0);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check("arst_fb_write", fb_write, 0);
    check("arst_busy", busy, 0);
    check("arst_ld_start", ld_start, 0);
    repeat (2) step();
    reset_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);
    s0 = starts;
    f0 = fb_cnt;
    repeat (20) @(negedge clk);
    check("post_rst_no_start", starts - s0, 0);
    check("post_rst_no_write", fb_cnt - f0, 0);
    check("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
